// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache (8 lines x 4 bytes) between the
// CPU load/store path and a word-organised data memory; busywait_o stalls the CPU on a miss.
module dcache_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     read_i,
  input  logic                     write_i,
  input  logic [ADDR_W-1:0]        address_i,
  input  logic [7:0]               writedata_i,
  output logic [7:0]               readdata_o,
  output logic                     busywait_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic [TAG_W+INDEX_W-1:0] mem_address_o,
  output logic [31:0]              mem_writedata_o,
  input  logic [31:0]              mem_readdata_i,
  input  logic                     mem_busywait_i
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WB, FETCH, UPDATE} state_e;

  state_e                   state_q;
  logic [LINES-1:0]         valid_q;
  logic [LINES-1:0]         dirty_q;
  logic [TAG_W-1:0]         tag_q  [LINES];
  logic [31:0]              data_q [LINES];
  logic                     seen_busy_q;
  logic                     mem_read_q;
  logic                     mem_write_q;
  logic [TAG_W+INDEX_W-1:0] mem_addr_q;
  logic [31:0]              mem_wdata_q;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  logic                hit;
  logic                access;
  logic                mem_done;

  assign addr_tag = address_i[ADDR_W-1 -: TAG_W];
  assign index    = address_i[OFFSET_W +: INDEX_W];
  assign offset   = address_i[OFFSET_W-1:0];
  assign hit      = valid_q[index] && (tag_q[index] == addr_tag);
  assign access   = read_i | write_i;
  // A memory phase ends only after busy has been seen and then dropped again.
  assign mem_done = seen_busy_q && !mem_busywait_i;

  assign readdata_o      = data_q[index][{offset, 3'b000} +: 8];
  assign busywait_o      = access && (!hit || state_q != IDLE);
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign mem_address_o   = mem_addr_q;
  assign mem_writedata_o = mem_wdata_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      seen_busy_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          seen_busy_q <= 1'b0;
          if (access && !hit) begin
            if (dirty_q[index]) begin
              state_q     <= WB;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[index], index};
              mem_wdata_q <= data_q[index];
            end else begin
              state_q    <= FETCH;
              mem_read_q <= 1'b1;
              mem_addr_q <= {addr_tag, index};
            end
          end else if (write_i && hit) begin
            data_q[index][{offset, 3'b000} +: 8] <= writedata_i;
            dirty_q[index]                       <= 1'b1;
          end
        end
        WB: begin
          if (mem_done) begin
            state_q     <= FETCH;
            seen_busy_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {addr_tag, index};
          end else if (mem_busywait_i) begin
            seen_busy_q <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_done) begin
            state_q     <= UPDATE;
            seen_busy_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
          end else if (mem_busywait_i) begin
            seen_busy_q <= 1'b1;
          end
        end
        UPDATE: begin
          data_q[index]  <= mem_readdata_i;
          tag_q[index]   <= addr_tag;
          valid_q[index] <= 1'b1;
          dirty_q[index] <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and word-organised data memory.
- Serves 8-bit loads and stores from the ALU/address path and returns load data to the register-file write port.
- Its BUSYWAIT output drives the register file's HOLD and the PC stall, so register updates freeze on a miss.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- INDEX_W, 3, index bits; 8 cache lines.
- OFFSET_W, 2, byte-offset bits; 4-byte lines.
- TAG_W, 3, ADDR_W-INDEX_W-OFFSET_W. Only the default configuration is required.

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  CPU load request.
- WRITE  input  1  CPU store request.
- ADDRESS  input  8  CPU byte address.
- WRITEDATA  input  8  store data.
- READDATA  output  8  load data, fed to the register-file write data.
- BUSYWAIT  output  1  stall to the CPU and the register-file HOLD.
- MEM_READ  output  1  block-fetch request.
- MEM_WRITE  output  1  block-writeback request.
- MEM_ADDRESS  output  6  block address {tag,index}.
- MEM_WRITEDATA  output  32  writeback block; byte0 = [7:0].
- MEM_READDATA  input  32  fetched block.
- MEM_BUSYWAIT  input  1  memory busy.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RESET is synchronous and active-high.
- Reset, sampled at posedge: state=IDLE, all valid=0, dirty=0, seen_busy=0. Tags and data are don't-care. MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, BUSYWAIT=0.
- Reset mid-operation aborts any fetch or writeback immediately. The line being filled stays invalid.
- Address split: tag=ADDRESS[7:5], index=[4:2], offset=[1:0].
- Per line storage: valid, dirty, 3-bit tag, 32-bit data.
- hit = valid[index] && tag[index]==tag (combinational).
- READDATA = byte[offset] of data[index] (combinational). It is meaningful only when READ && hit.
- WRITE && READ both high is treated as WRITE.
- States and transitions:
  - IDLE: if (READ|WRITE) and !hit:
    - dirty[index] -> WB
    - else -> FETCH
  - WB:
    - MEM_WRITE=1, MEM_ADDRESS={tag[index],index}, MEM_WRITEDATA=data[index].
    - Leave to FETCH on a posedge with MEM_BUSYWAIT=0 and seen_busy=1.
  - FETCH:
    - MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5],index}.
    - Leave to UPDATE under the same exit rule as WB.
  - UPDATE, one cycle: at its closing posedge:
    - data[index]=MEM_READDATA, tag[index]=tag, valid=1, dirty=0.
    - -> IDLE.
- Memory handshake:
  - seen_busy is set when MEM_BUSYWAIT=1 is sampled in WB or FETCH, and is cleared on every state change.
  - This tolerates memories that raise busy one cycle late.
  - MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA are held stable for the whole state. Both requests are low outside WB/FETCH.
- BUSYWAIT = (READ|WRITE) && (!hit || state!=IDLE). It is high from the miss cycle through UPDATE, then drops once the replayed access hits in IDLE.
- CPU rule: READ, WRITE, ADDRESS and WRITEDATA are held stable while BUSYWAIT=1.
- Read hit: zero stall. BUSYWAIT stays 0 and READDATA is valid in the same cycle.
- Write hit, in IDLE: at posedge, byte[offset] of data[index]=WRITEDATA and dirty=1. Zero stall.
- Miss latency (miss cycle counts as IDLE):
  - clean miss = 1 (IDLE) + FETCH cycles + 1 (UPDATE), then hit.
  - dirty miss adds the WB cycles.
- A store miss completes as a write hit after refill, so the line ends dirty.
- No state change in IDLE when READ=WRITE=0.

Test Plan:
- Reset, then READ ADDRESS=0x05 with memory returning 0x44332211 after 3 busy cycles:
  - BUSYWAIT high through UPDATE.
  - MEM_ADDRESS=0x01.
  - READDATA=0x22.
  - valid[1]=1, dirty[1]=0.
- Then READ 0x07: zero stall, READDATA=0x44, MEM_READ never asserted.
- WRITE 0x06 data 0xAB (hit): no stall, dirty[1]=1. A following READ 0x06 returns 0xAB.
- READ 0x25 (same index, tag 1, line dirty):
  - WB first with MEM_WRITE=1, MEM_ADDRESS=0x01, MEM_WRITEDATA=0x44AB2211.
  - Then FETCH with MEM_ADDRESS=0x09, then hit.
- WRITE miss to clean index 2, ADDRESS=0x4A, data 0x7F:
  - fetch from MEM_ADDRESS=0x12, refill, then byte2=0x7F.
  - dirty[2]=1, BUSYWAIT low after replay.
- RESET asserted during FETCH:
  - next cycle state=IDLE, MEM_READ=0, all valid=0.
  - A subsequent READ 0x07 misses.
